// File: rtl/wb_csr_bridge_pkg.sv
// rtl/wb_csr_bridge_pkg.sv - shared types, widths and byte-merge helper for the WB-to-CSR bridge
package wb_csr_bridge_pkg;

    localparam int CSR_AW_DEF = 14;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RWAIT = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    // Byte n of the result comes from new_d when sel[n] is set, otherwise from old_d.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_d,
                                               input logic [31:0] new_d,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int n = 0; n < 4; n++) begin
            r[8*n +: 8] = sel[n] ? new_d[8*n +: 8] : old_d[8*n +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_csr_bridge_if.sv
// rtl/wb_csr_bridge_if.sv - Wishbone slave side plus CSR bus side of the bridge
interface wb_csr_bridge_if import wb_csr_bridge_pkg::*; #(
    parameter int CSR_AW = CSR_AW_DEF
);
    logic [31:0]       wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [31:0]       wb_dat_o;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_ack_o;
    logic [CSR_AW-1:0] csr_a;
    logic              csr_we;
    logic [31:0]       csr_do;
    logic [31:0]       csr_di;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, csr_di,
        output wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, csr_di,
        input  wb_dat_o, wb_ack_o, csr_a, csr_we, csr_do
    );

endinterface

// File: rtl/wb_csr_bridge.sv
// rtl/wb_csr_bridge.sv - classic Wishbone slave translated to the single-word CSR bus
module wb_csr_bridge import wb_csr_bridge_pkg::*; #(
    parameter int CSR_AW   = CSR_AW_DEF,
    parameter int READ_LAT = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    wb_csr_bridge_if.slave      bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CSR_AW-1:0]  csr_a_q, csr_a_d;
    logic [31:0]        csr_do_q, csr_do_d;
    logic               csr_we_q, csr_we_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_o_q, dat_o_d;
    logic               is_wr_q, is_wr_d;
    logic [3:0]         sel_q, sel_d;
    logic [31:0]        wdat_q, wdat_d;

    logic unused_adr_bits;
    assign unused_adr_bits = ^{bus.wb_adr_i[31:CSR_AW+2], bus.wb_adr_i[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        csr_a_d  = csr_a_q;
        csr_do_d = csr_do_q;
        csr_we_d = 1'b0;
        ack_d    = 1'b0;
        dat_o_d  = dat_o_q;
        is_wr_d  = is_wr_q;
        sel_d    = sel_q;
        wdat_d   = wdat_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    csr_a_d = bus.wb_adr_i[CSR_AW+1:2];
                    is_wr_d = bus.wb_we_i;
                    sel_d   = bus.wb_sel_i;
                    wdat_d  = bus.wb_dat_i;
                    if (bus.wb_we_i && bus.wb_sel_i == 4'hF) begin
                        csr_do_d = bus.wb_dat_i;
                        csr_we_d = 1'b1;
                        state_d  = ST_WRITE;
                    end else if (bus.wb_we_i && bus.wb_sel_i == 4'h0) begin
                        state_d  = ST_WRITE;
                    end else begin
                        cnt_d    = CNT_W'(READ_LAT - 1);
                        state_d  = ST_RWAIT;
                    end
                end
            end
            ST_RWAIT: begin
                if (cnt_q == '0) begin
                    if (is_wr_q) begin
                        // Partial write: merge the fresh CSR word with the latched bytes.
                        csr_do_d = byte_merge(bus.csr_di, wdat_q, sel_q);
                        csr_we_d = 1'b1;
                        state_d  = ST_WRITE;
                    end else begin
                        dat_o_d  = bus.csr_di;
                        ack_d    = bus.wb_cyc_i;
                        state_d  = ST_ACK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: begin
                ack_d   = bus.wb_cyc_i;
                state_d = ST_ACK;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            csr_a_q  <= '0;
            csr_do_q <= '0;
            csr_we_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_o_q  <= '0;
            is_wr_q  <= 1'b0;
            sel_q    <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            csr_a_q  <= csr_a_d;
            csr_do_q <= csr_do_d;
            csr_we_q <= csr_we_d;
            ack_q    <= ack_d;
            dat_o_q  <= dat_o_d;
            is_wr_q  <= is_wr_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
        end
    end

    assign bus.csr_a    = csr_a_q;
    assign bus.csr_do   = csr_do_q;
    assign bus.csr_we   = csr_we_q;
    assign bus.wb_ack_o = ack_q;
    assign bus.wb_dat_o = dat_o_q;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// tb/tb_wb_csr_bridge.sv - bench for wb_csr_bridge with READ_LAT=1 and READ_LAT=3 instances
module tb_wb_csr_bridge;

    typedef struct {
        logic        is_rd;
        logic [13:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        cyc [2];
    logic        stb [2];
    logic [31:0] mem [16];

    exp_t aq [2][$];
    exp_t wq [2][$];
    int   ack_cnt  [2];
    logic prev_ack [2];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wb_csr_bridge_if #(.CSR_AW(14)) if1 ();
    wb_csr_bridge_if #(.CSR_AW(14)) if3 ();

    assign if1.wb_adr_i = adr;  assign if3.wb_adr_i = adr;
    assign if1.wb_dat_i = dat;  assign if3.wb_dat_i = dat;
    assign if1.wb_sel_i = sel;  assign if3.wb_sel_i = sel;
    assign if1.wb_we_i  = we;   assign if3.wb_we_i  = we;
    assign if1.wb_cyc_i = cyc[0];
    assign if1.wb_stb_i = stb[0];
    assign if3.wb_cyc_i = cyc[1];
    assign if3.wb_stb_i = stb[1];
    assign if1.csr_di   = mem[if1.csr_a[3:0]];
    assign if3.csr_di   = mem[if3.csr_a[3:0]];

    wb_csr_bridge #(.CSR_AW(14), .READ_LAT(1)) dut1 (.sys_clk(clk), .sys_rst(rst), .bus(if1.slave));
    wb_csr_bridge #(.CSR_AW(14), .READ_LAT(3)) dut3 (.sys_clk(clk), .sys_rst(rst), .bus(if3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int i);
        return (i == 0) ? if1.wb_ack_o : if3.wb_ack_o;
    endfunction

    task automatic mon(input int i, input logic ack, input logic [31:0] dato,
                       input logic [13:0] a, input logic csr_we, input logic [31:0] csr_do);
        exp_t e;
        if (!rst) begin
            if (ack) begin
                ack_cnt[i]++;
                chk($sformatf("ack_expected[%0d]", i), 32'(aq[i].size() > 0), 32'd1);
                if (aq[i].size() > 0) begin
                    e = aq[i].pop_front();
                    if (e.is_rd) begin
                        chk($sformatf("rd_data[%0d]", i), dato, e.d);
                        chk($sformatf("rd_addr[%0d]", i), 32'(a), 32'(e.a));
                    end
                end
                chk($sformatf("ack_not_back_to_back[%0d]", i), 32'(prev_ack[i]), 32'd0);
            end
            if (csr_we) begin
                chk($sformatf("csr_we_expected[%0d]", i), 32'(wq[i].size() > 0), 32'd1);
                if (wq[i].size() > 0) begin
                    e = wq[i].pop_front();
                    chk($sformatf("csr_wr_addr[%0d]", i), 32'(a), 32'(e.a));
                    chk($sformatf("csr_wr_data[%0d]", i), csr_do, e.d);
                end
            end
        end
        prev_ack[i] = ack;
    endtask

    always @(negedge clk) begin
        mon(0, if1.wb_ack_o, if1.wb_dat_o, if1.csr_a, if1.csr_we, if1.csr_do);
        mon(1, if3.wb_ack_o, if3.wb_dat_o, if3.csr_a, if3.csr_we, if3.csr_do);
    end

    task automatic wait_ack(input int i, input string tag, output int n);
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            got = ack_of(i);
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    endtask

    // Single transaction with scoreboard push, latency check and stb drop after the ack edge.
    task automatic txn(input int i, input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w, input logic [31:0] exp_d,
                       input logic push_wr, input int exp_lat);
        int n;
        exp_t e;
        e.is_rd = !w;
        e.a     = a[15:2];
        e.d     = exp_d;
        aq[i].push_back(e);
        if (push_wr) wq[i].push_back(e);
        adr = a; dat = d; sel = s; we = w;
        cyc[i] = 1'b1; stb[i] = 1'b1;
        wait_ack(i, tag, n);
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        int   base;
        logic [31:0] b2b_adr [3];
        logic [31:0] b2b_dat [3];

        cyc[0] = 1'b0; cyc[1] = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
        ack_cnt[0] = 0; ack_cnt[1] = 0; prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
        for (int k = 0; k < 16; k++) mem[k] = '0;
        mem[1] = 32'hA1A1_A1A1; mem[2] = 32'hB2B2_B2B2; mem[3] = 32'hC3C3_C3C3;
        mem[4] = 32'hDEAD_BEEF; mem[5] = 32'h5555_5555; mem[6] = 32'h1122_3344;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack1",   32'(if1.wb_ack_o), 32'd0);
        chk("rst_we1",    32'(if1.csr_we),   32'd0);
        chk("rst_a1",     32'(if1.csr_a),    32'd0);
        chk("rst_do1",    if1.csr_do,        32'd0);
        chk("rst_dato1",  if1.wb_dat_o,      32'd0);
        chk("rst_ack3",   32'(if3.wb_ack_o), 32'd0);
        chk("rst_a3",     32'(if3.csr_a),    32'd0);
        @(posedge clk); #1 rst = 1'b0;

        txn(0, "read_lat1",   32'h6000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 2);
        txn(0, "full_write",  32'h6000_0008, 32'h1234_5678, 4'hF, 1'b1, 32'h1234_5678, 1'b1, 2);
        chk("full_write_a_hold",  32'(if1.csr_a), 32'd2);
        chk("full_write_do_hold", if1.csr_do,     32'h1234_5678);
        txn(0, "partial_lat1", 32'h6000_0018, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h11BB_33DD, 1'b1, 3);
        txn(1, "partial_lat3", 32'h6000_0018, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h11BB_33DD, 1'b1, 5);
        txn(0, "null_write",  32'h6000_000C, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0, 1'b0, 2);
        chk("null_write_do_hold", if1.csr_do, 32'h11BB_33DD);
        txn(1, "read_wrap_lat3", 32'hFFFF_0013, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 4);

        b2b_adr[0] = 32'h6000_0004; b2b_adr[1] = 32'h6000_0008; b2b_adr[2] = 32'h6000_000C;
        b2b_dat[0] = 32'hA1A1_A1A1; b2b_dat[1] = 32'hB2B2_B2B2; b2b_dat[2] = 32'hC3C3_C3C3;
        base = ack_cnt[0];
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b0; sel = 4'hF;
        for (int k = 0; k < 3; k++) begin
            e.is_rd = 1'b1; e.a = b2b_adr[k][15:2]; e.d = b2b_dat[k];
            aq[0].push_back(e);
            adr = b2b_adr[k];
            wait_ack(0, "b2b", n);
            @(posedge clk); #1;
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("b2b_ack_count", 32'(ack_cnt[0] - base), 32'd3);

        base = ack_cnt[1];
        adr = 32'h6000_0014; we = 1'b0; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("drop_cyc_read_no_ack", 32'(ack_cnt[1] - base), 32'd0);

        e.is_rd = 1'b0; e.a = 14'd6; e.d = 32'hAABB_3344;
        wq[1].push_back(e);
        adr = 32'h6000_0018; dat = 32'hAABB_CCDD; we = 1'b1; sel = 4'b1100;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("drop_cyc_write_no_ack", 32'(ack_cnt[1] - base), 32'd0);
        chk("drop_cyc_write_done", 32'(wq[1].size()), 32'd0);

        adr = 32'h6000_0014; we = 1'b0; sel = 4'hF;
        cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ack",  32'(if3.wb_ack_o), 32'd0);
        chk("midrst_we",   32'(if3.csr_we),   32'd0);
        chk("midrst_a",    32'(if3.csr_a),    32'd0);
        chk("midrst_do",   if3.csr_do,        32'd0);
        chk("midrst_dato", if3.wb_dat_o,      32'd0);
        @(posedge clk); #1 rst = 1'b0;

        txn(1, "post_rst_read", 32'h6000_0004, 32'h0, 4'hF, 1'b0, 32'hA1A1_A1A1, 1'b0, 4);
        repeat (3) @(posedge clk);
        #1;
        chk("aq0_drained", 32'(aq[0].size()), 32'd0);
        chk("aq1_drained", 32'(aq[1].size()), 32'd0);
        chk("wq0_drained", 32'(wq[0].size()), 32'd0);
        chk("wq1_drained", 32'(wq[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
